rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/crg_pkg.sv | 23 ++
 rtl/rst_seq.sv | 174 +++++++++++++++++
 tb/tb_rst_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crg_pkg.sv
// Shared clock/reset-generation definitions: reset sequencer state encoding
// and the default sequencing parameters used by the CRG blocks.
package crg_pkg;

  // Reset sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    HOLD    = 2'd3
  } rst_seq_state_t;

  // Default sequencing parameters.
  localparam int RST_SEQ_NUM_STAGES_DEF  = 4;
  localparam int RST_SEQ_STAGE_GAP_DEF   = 16;
  localparam int RST_SEQ_SW_RST_HOLD_DEF = 8;

  // Larger of two integers, used to size the shared gap/hold counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq.sv
// Reset sequencer: once the upstream power-on delay reports ready, releases
// NUM_STAGES active-low reset domains in order, STAGE_GAP cycles apart.
// A software request pulls every domain back into reset for SW_RST_HOLD
// cycles and then re-runs the release sequence; losing ready aborts to IDLE.
//
// Handshake: none in the valid/ready sense. ready_i is a level (1 = power-on
// delay elapsed, must stay 1 for the sequence to progress); sw_rst_req_i is a
// single-cycle pulse sampled on the rising edge. All outputs come straight
// from flops.
import crg_pkg::*;

module rst_seq #(
  parameter int NUM_STAGES  = RST_SEQ_NUM_STAGES_DEF,
  parameter int STAGE_GAP   = RST_SEQ_STAGE_GAP_DEF,
  parameter int SW_RST_HOLD = RST_SEQ_SW_RST_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  ready_i,
  input  logic                  sw_rst_req_i,
  output logic [NUM_STAGES-1:0] rst_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output rst_seq_state_t        dbg_state
);

  // Counter only ever reaches max(gap, hold) - 1 before clearing; the +1
  // keeps the width safe for the degenerate value 1.
  localparam int CNT_MAX = max_int(STAGE_GAP, SW_RST_HOLD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_RST_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  rst_seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // State, counters and every output are registered; async reset clears all.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Priority in the active states: ready loss first, then
  // a software request, then the gap/hold timing. Every state entry clears
  // the shared counter and the stage index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;

    case (state_q)
      IDLE: begin
        stage_d = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        // The edge sampling ready is release-cycle 0.
        if (ready_i) begin
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (!ready_i) begin
          state_d = IDLE;
          stage_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (sw_rst_req_i) begin
          state_d = HOLD;
          stage_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          // Release the stage the index points at; index stays <= NUM_STAGES.
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == idx_q) begin
              stage_d[i] = 1'b1;
            end
          end
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        if (!ready_i) begin
          state_d = IDLE;
          stage_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (sw_rst_req_i) begin
          state_d = HOLD;
          stage_d = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      HOLD: begin
        stage_d = '0;
        done_d  = 1'b0;
        if (!ready_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (sw_rst_req_i) begin
          // A repeated request restarts the hold window from this edge.
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          // ready is known to be 1 here, so this edge is release-cycle 0.
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        stage_d = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // busy is registered from the next state so it is valid right after the edge.
  always_comb begin
    busy_d = (state_d == RELEASE) || (state_d == HOLD);
  end

  assign rst_n_o   = stage_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a default 4/16/8 instance and a 1-stage,
// gap-1 instance share clock and async reset. Stimulus pushes expected
// output snapshots tagged with an absolute edge number; a negedge monitor
// compares them when that edge has passed.
import crg_pkg::*;

module tb_rst_seq;

  // ---------------- clock / reset ----------------
  logic clk;
  logic arst_n;
  int   edge_no;

  initial begin
    clk     = 1'b0;
    edge_no = 0;
  end
  always #5 clk = ~clk;

  // Absolute count of rising edges since time 0.
  always @(posedge clk) edge_no = edge_no + 1;

  // ---------------- DUTs ----------------
  logic           ready0, sw0;
  logic [3:0]     rst0;
  logic           busy0, done0;
  rst_seq_state_t st0;

  logic           ready1, sw1;
  logic [0:0]     rst1;
  logic           busy1, done1;
  rst_seq_state_t st1;

  rst_seq #(.NUM_STAGES(4), .STAGE_GAP(16), .SW_RST_HOLD(8)) dut0 (
    .clk          (clk),
    .arst_n       (arst_n),
    .ready_i      (ready0),
    .sw_rst_req_i (sw0),
    .rst_n_o      (rst0),
    .busy_o       (busy0),
    .done_o       (done0),
    .dbg_state    (st0)
  );

  rst_seq #(.NUM_STAGES(1), .STAGE_GAP(1), .SW_RST_HOLD(8)) dut1 (
    .clk          (clk),
    .arst_n       (arst_n),
    .ready_i      (ready1),
    .sw_rst_req_i (sw1),
    .rst_n_o      (rst1),
    .busy_o       (busy1),
    .done_o       (done1),
    .dbg_state    (st1)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int             at;
    int             unit;
    logic [3:0]     rst;
    logic           busy;
    logic           done;
    rst_seq_state_t st;
    string          name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string name, input int unit, input int at,
                      input logic [3:0] rst, input logic busy, input logic done,
                      input rst_seq_state_t st);
    exp_t e;
    e.at = at; e.unit = unit; e.rst = rst; e.busy = busy; e.done = done;
    e.st = st; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [3:0]     a_rst;
    logic           a_busy, a_done;
    rst_seq_state_t a_st;
    if (e.unit == 0) begin
      a_rst = rst0; a_busy = busy0; a_done = done0; a_st = st0;
    end else begin
      a_rst = {3'b000, rst1}; a_busy = busy1; a_done = done1; a_st = st1;
    end
    n_cmp++;
    if (a_rst !== e.rst || a_busy !== e.busy || a_done !== e.done || a_st !== e.st) begin
      n_bad++;
      $display("FAIL %s unit%0d edge %0d: got rst_n_o=%b busy=%b done=%b state=%s, want rst_n_o=%b busy=%b done=%b state=%s",
               e.name, e.unit, e.at, a_rst, a_busy, a_done, a_st.name(),
               e.rst, e.busy, e.done, e.st.name());
    end
  endtask

  // Monitor: checks every expectation whose edge has passed.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at == edge_no) begin
        compare(exp_q[i]);
        exp_q.delete(i);
      end else if (exp_q[i].at < edge_no) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s unit%0d: expectation for edge %0d missed (now %0d)",
                 exp_q[i].name, exp_q[i].unit, exp_q[i].at, edge_no);
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_no < e) next_edge();
  endtask

  task automatic check_now(input string name, input int unit,
                           input logic [3:0] rst, input logic busy, input logic done,
                           input rst_seq_state_t st);
    exp_t e;
    e.at = edge_no; e.unit = unit; e.rst = rst; e.busy = busy; e.done = done;
    e.st = st; e.name = name;
    compare(e);
  endtask

  // ---------------- stimulus ----------------
  int e0, d0, b0, r0, s0, t0;

  initial begin
    arst_n = 1'b0;
    ready0 = 1'b0; sw0 = 1'b0;
    ready1 = 1'b0; sw1 = 1'b0;

    // Reset state while arst_n is low.
    next_edge();
    check_now("reset0", 0, 4'b0000, 1'b0, 1'b0, IDLE);
    check_now("reset1", 1, 4'b0000, 1'b0, 1'b0, IDLE);

    run_to(3);
    arst_n = 1'b1;
    push("first_edge_idle", 0, 4, 4'b0000, 1'b0, 1'b0, IDLE);
    run_to(4);

    // Power-on release sequence; edge e0 is release-cycle 0.
    ready0 = 1'b1; ready1 = 1'b1;
    e0 = edge_no + 1;
    push("rel_c0",       0, e0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("rel_15",       0, e0 + 15, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("rel_s0",       0, e0 + 16, 4'b0001, 1'b1, 1'b0, RELEASE);
    push("rel_s1",       0, e0 + 32, 4'b0011, 1'b1, 1'b0, RELEASE);
    push("rel_s2",       0, e0 + 48, 4'b0111, 1'b1, 1'b0, RELEASE);
    push("rel_63",       0, e0 + 63, 4'b0111, 1'b1, 1'b0, RELEASE);
    push("rel_s3_done",  0, e0 + 64, 4'b1111, 1'b0, 1'b1, RUN);
    push("one_stage_c0", 1, e0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("one_stage_e1", 1, e0 + 1,  4'b0001, 1'b0, 1'b1, RUN);

    // Software reset from RUN at edge e0+100.
    push("sw_hold",      0, e0 + 100, 4'b0000, 1'b1, 1'b0, HOLD);
    push("sw_hold_end",  0, e0 + 107, 4'b0000, 1'b1, 1'b0, HOLD);
    push("sw_rel_c0",    0, e0 + 108, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("sw_123",       0, e0 + 123, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("sw_s0",        0, e0 + 124, 4'b0001, 1'b1, 1'b0, RELEASE);
    push("sw_all_done",  0, e0 + 172, 4'b1111, 1'b0, 1'b1, RUN);
    run_to(e0 + 99);
    sw0 = 1'b1;
    run_to(e0 + 100);
    sw0 = 1'b0;
    run_to(e0 + 180);

    // ready drop from RUN, then from mid-RELEASE at release-cycle 40.
    d0 = edge_no + 1;
    b0 = d0 + 1;
    push("drop_run",     0, d0,      4'b0000, 1'b0, 1'b0, IDLE);
    push("r2_c0",        0, b0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("r2_s1",        0, b0 + 32, 4'b0011, 1'b1, 1'b0, RELEASE);
    push("drop_rel",     0, b0 + 40, 4'b0000, 1'b0, 1'b0, IDLE);
    push("drop_stay",    0, b0 + 41, 4'b0000, 1'b0, 1'b0, IDLE);
    ready0 = 1'b0;
    run_to(d0);
    ready0 = 1'b1;
    run_to(b0 + 39);
    ready0 = 1'b0;
    run_to(b0 + 44);

    // Restart from stage 0, then hold restart and ready-vs-sw priority.
    ready0 = 1'b1;
    r0 = b0 + 45;
    push("r3_c0",        0, r0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("r3_15",        0, r0 + 15, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("r3_s0",        0, r0 + 16, 4'b0001, 1'b1, 1'b0, RELEASE);
    push("rel_sw_hold",  0, r0 + 20, 4'b0000, 1'b1, 1'b0, HOLD);
    push("hold_restart", 0, r0 + 32, 4'b0000, 1'b1, 1'b0, HOLD);
    push("hold_rel_c0",  0, r0 + 33, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("hold_rel_48",  0, r0 + 48, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("hold_rel_s0",  0, r0 + 49, 4'b0001, 1'b1, 1'b0, RELEASE);
    push("drop_vs_sw",   0, r0 + 60, 4'b0000, 1'b0, 1'b0, IDLE);
    push("drop_vs_sw2",  0, r0 + 61, 4'b0000, 1'b0, 1'b0, IDLE);
    run_to(r0 + 19);
    sw0 = 1'b1;
    run_to(r0 + 20);
    sw0 = 1'b0;
    run_to(r0 + 24);
    sw0 = 1'b1;
    run_to(r0 + 25);
    sw0 = 1'b0;
    run_to(r0 + 59);
    ready0 = 1'b0; sw0 = 1'b1;
    run_to(r0 + 60);
    sw0 = 1'b0;
    run_to(r0 + 62);

    // Reach RUN, then pulse arst_n between edges.
    ready0 = 1'b1;
    s0 = r0 + 63;
    push("r4_c0",        0, s0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("r4_done",      0, s0 + 64, 4'b1111, 1'b0, 1'b1, RUN);
    run_to(s0 + 70);
    #1 arst_n = 1'b0;
    #1;
    check_now("async_rst0", 0, 4'b0000, 1'b0, 1'b0, IDLE);
    check_now("async_rst1", 1, 4'b0000, 1'b0, 1'b0, IDLE);
    #1 arst_n = 1'b1;

    // Progress was discarded: sequence restarts from stage 0.
    t0 = edge_no + 1;
    push("post_rst_c0",  0, t0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("post_rst_15",  0, t0 + 15, 4'b0000, 1'b1, 1'b0, RELEASE);
    push("post_rst_s0",  0, t0 + 16, 4'b0001, 1'b1, 1'b0, RELEASE);
    push("post_rst1_c0", 1, t0,      4'b0000, 1'b1, 1'b0, RELEASE);
    push("post_rst1_e1", 1, t0 + 1,  4'b0001, 1'b0, 1'b1, RUN);
    run_to(t0 + 20);
    @(negedge clk);
    #1;

    // ---------------- report ----------------
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
